// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction register and next-PC selection for the load/store FSM
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        ir_load,
  input  logic [15:0] ram_dout,
  input  logic [1:0]  br_kind,
  input  logic [3:0]  cond,
  input  logic [7:0]  disp,
  input  logic [15:0] target,
  input  logic [4:0]  flags_in,
  output logic [15:0] pc_out,
  output logic [15:0] instr_out,
  output logic [15:0] link_addr,
  output logic        taken,
  output logic [15:0] retired
);
  logic [15:0] pc_q, pc_d, ir_q, ir_d, retired_q, retired_d, seq, rel, next_pc;
  logic        taken_q, taken_d, cond_true, redirect;
  logic        c, l, f, z, n;
  logic [15:0] cond_vec;
  // condition evaluation and next-PC selection
  always_comb begin
    {c, l, f, z, n} = flags_in;
    cond_vec  = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !f, f, !n, n, !l, l, !c, c, !z, z};
    cond_true = cond_vec[cond];
    seq       = pc_q + 16'd1;
    rel       = pc_q + {{8{disp[7]}}, disp};
    redirect  = (br_kind == 2'b11) || ((br_kind[0] ^ br_kind[1]) && cond_true);
    next_pc   = !redirect ? seq : (br_kind == 2'b01) ? rel : target;
    pc_d      = pc_en ? next_pc : pc_q;
    taken_d   = pc_en && redirect;
    retired_d = pc_en ? retired_q + 16'd1 : retired_q;
    ir_d      = ir_load ? ram_dout : ir_q;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= IR_RESET;
      taken_q   <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      taken_q   <= taken_d;
      retired_q <= retired_d;
    end
  end
  assign pc_out    = pc_q;
  assign instr_out = ir_load ? ram_dout : ir_q;
  assign link_addr = seq;
  assign taken     = taken_q;
  assign retired   = retired_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_en = 1'b0;
  logic        ir_load = 1'b0;
  logic [15:0] ram_dout = 16'h0000;
  logic [1:0]  br_kind = 2'b00;
  logic [3:0]  cond = 4'h0;
  logic [7:0]  disp = 8'h00;
  logic [15:0] target = 16'h0000;
  logic [4:0]  flags_in = 5'b00000;
  logic [15:0] pc_out, instr_out, link_addr, retired;
  logic        taken;
  int errors = 0;
  int checks = 0;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .ir_load(ir_load), .ram_dout(ram_dout),
    .br_kind(br_kind), .cond(cond), .disp(disp), .target(target), .flags_in(flags_in),
    .pc_out(pc_out), .instr_out(instr_out), .link_addr(link_addr), .taken(taken),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    br_kind = 2'b11;
    target  = v;
    pc_en   = 1'b1;
    tick();
    pc_en   = 1'b0;
    br_kind = 2'b00;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc_out); end
    checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h exp=0000", instr_out); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%b exp=0", taken); end
    checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL reset_retired got=%h exp=0000", retired); end
    checks++; if (link_addr !== 16'h0001) begin errors++; $display("FAIL reset_link got=%h exp=0001", link_addr); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_seq();
    pc_en = 1'b1;
    br_kind = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc_out !== 16'(i)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc_out, 16'(i)); end
      checks++; if (taken !== 1'b0) begin errors++; $display("FAIL seq_taken%0d got=%b exp=0", i, taken); end
    end
    pc_en = 1'b0;
    tick();
    checks++; if (retired !== 16'd3) begin errors++; $display("FAIL seq_retired got=%h exp=0003", retired); end
    checks++; if (pc_out !== 16'h0003) begin errors++; $display("FAIL seq_hold got=%h exp=0003", pc_out); end
  endtask

  task automatic test_ir();
    ir_load = 1'b1;
    ram_dout = 16'hD305;
    #1;
    checks++; if (instr_out !== 16'hD305) begin errors++; $display("FAIL ir_bypass got=%h exp=D305", instr_out); end
    tick();
    ir_load = 1'b0;
    ram_dout = 16'h1234;
    #1;
    checks++; if (instr_out !== 16'hD305) begin errors++; $display("FAIL ir_hold got=%h exp=D305", instr_out); end
    tick();
    checks++; if (instr_out !== 16'hD305) begin errors++; $display("FAIL ir_hold2 got=%h exp=D305", instr_out); end
  endtask

  task automatic test_bcond();
    set_pc(16'h0010);
    br_kind = 2'b01; cond = 4'h0; disp = 8'hFC; flags_in = 5'b00010; pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    checks++; if (pc_out !== 16'h000C) begin errors++; $display("FAIL bcond_taken_pc got=%h exp=000C", pc_out); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL bcond_taken got=%b exp=1", taken); end
    tick();
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bcond_pulse got=%b exp=0", taken); end
    set_pc(16'h0010);
    br_kind = 2'b01; cond = 4'h0; disp = 8'hFC; flags_in = 5'b00000; pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    checks++; if (pc_out !== 16'h0011) begin errors++; $display("FAIL bcond_nt_pc got=%h exp=0011", pc_out); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bcond_nt_taken got=%b exp=0", taken); end
    set_pc(16'h0000);
    br_kind = 2'b01; cond = 4'hE; disp = 8'hFC; pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    checks++; if (pc_out !== 16'hFFFC) begin errors++; $display("FAIL bcond_wrap got=%h exp=FFFC", pc_out); end
    set_pc(16'h0100);
    br_kind = 2'b01; cond = 4'hE; disp = 8'h7F; pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    checks++; if (pc_out !== 16'h017F) begin errors++; $display("FAIL bcond_fwd got=%h exp=017F", pc_out); end
  endtask

  task automatic test_jal();
    set_pc(16'h0020);
    br_kind = 2'b11; cond = 4'hF; target = 16'h0100; pc_en = 1'b1;
    #1;
    checks++; if (link_addr !== 16'h0021) begin errors++; $display("FAIL jal_link got=%h exp=0021", link_addr); end
    checks++; if (pc_out !== 16'h0020) begin errors++; $display("FAIL jal_precommit got=%h exp=0020", pc_out); end
    tick();
    pc_en = 1'b0;
    checks++; if (pc_out !== 16'h0100) begin errors++; $display("FAIL jal_pc got=%h exp=0100", pc_out); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL jal_taken got=%b exp=1", taken); end
  endtask

  task automatic test_wrap_jcond();
    set_pc(16'hFFFF);
    br_kind = 2'b00; pc_en = 1'b1;
    tick();
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000", pc_out); end
    br_kind = 2'b10; cond = 4'hF; target = 16'h0055;
    tick();
    checks++; if (pc_out !== 16'h0001) begin errors++; $display("FAIL jcond_never_pc got=%h exp=0001", pc_out); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL jcond_never_taken got=%b exp=0", taken); end
    cond = 4'hE;
    tick();
    pc_en = 1'b0;
    checks++; if (pc_out !== 16'h0055) begin errors++; $display("FAIL jcond_uc_pc got=%h exp=0055", pc_out); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL jcond_uc_taken got=%b exp=1", taken); end
  endtask

  task automatic test_conds();
    logic [4:0]  pats  [2] = '{5'b10101, 5'b01010};
    logic [15:0] masks [2] = '{16'h6566, 16'h6A99};
    logic [15:0] m;
    for (int p = 0; p < 2; p++) begin
      m = masks[p];
      for (int k = 0; k < 16; k++) begin
        set_pc(16'h0100);
        br_kind = 2'b01; cond = 4'(k); disp = 8'h02; flags_in = pats[p]; pc_en = 1'b1;
        tick();
        pc_en = 1'b0;
        checks++;
        if (pc_out !== (m[k] ? 16'h0102 : 16'h0101) || taken !== m[k]) begin
          errors++;
          $display("FAIL cond_p%0d_c%0h got pc=%h taken=%b exp pc=%h taken=%b", p, k, pc_out, taken,
                   m[k] ? 16'h0102 : 16'h0101, m[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    set_pc(16'h0200);
    ir_load = 1'b1; ram_dout = 16'hABCD; br_kind = 2'b00; pc_en = 1'b1;
    tick();
    ir_load = 1'b0; pc_en = 1'b0; ram_dout = 16'h0000;
    #1;
    checks++; if (instr_out !== 16'hABCD) begin errors++; $display("FAIL simul_ir got=%h exp=ABCD", instr_out); end
    checks++; if (pc_out !== 16'h0201) begin errors++; $display("FAIL simul_pc got=%h exp=0201", pc_out); end
  endtask

  task automatic test_reset_mid();
    set_pc(16'h0042);
    ir_load = 1'b1; ram_dout = 16'hD305;
    tick();
    ir_load = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL areset_pc got=%h exp=0000", pc_out); end
    checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL areset_ir got=%h exp=0000", instr_out); end
    checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL areset_retired got=%h exp=0000", retired); end
    pc_en = 1'b1; ir_load = 1'b1; ram_dout = 16'hFFFF; br_kind = 2'b11; target = 16'h1234;
    tick();
    tick();
    ir_load = 1'b0; pc_en = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL rhold_pc got=%h exp=0000", pc_out); end
    checks++; if (instr_out !== 16'h0000) begin errors++; $display("FAIL rhold_ir got=%h exp=0000", instr_out); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL rhold_taken got=%b exp=0", taken); end
    checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL rhold_retired got=%h exp=0000", retired); end
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_seq();
    test_ir();
    test_bcond();
    test_jal();
    test_wrap_jcond();
    test_conds();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
